// File: rtl/pc_gen.sv
// Fetch-stage program counter.
// Owns the PC and EPC registers. Resolves the branch/jump next-address rules,
// trap entry and return, misaligned JR targets and halt, all under the fetch
// handshake.
//
// Handshake: fetch_valid is a function of state only. A fetch completes on a
// rising edge where fetch_valid & fetch_ready & ctrl_valid are all high
// ("advance"). Until that happens, pc holds unless trap, eret or halt_req
// intervenes.
module pc_gen #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter logic [31:0] JUMP_BASE = 32'h0000_3000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  input  logic              ctrl_valid,
  input  logic [1:0]        branch,
  input  logic              jump,
  input  logic              zero,
  input  logic [5:0]        op,
  input  logic [15:0]       imm16,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] busA,
  input  logic              trap,
  input  logic              eret,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] epc,
  output logic              in_trap,
  output logic              misalign,
  output logic              halted,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] JUMP_OFS  = ADDR_W'(JUMP_BASE);
  localparam logic [ADDR_W-1:0] TRAP_PC   = ADDR_W'(TRAP_VEC);
  localparam logic [ADDR_W-1:0] INSN_SIZE = ADDR_W'(4);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt, epc_nxt;
  logic              misalign_nxt;

  logic              advance;
  logic              take_br;
  logic              is_jr;
  logic [ADDR_W-1:0] seq_pc, br_pc, jr_pc, j_pc, redirect_pc;

  assign fetch_valid = (state == RUN) || (state == TRAP);
  assign advance     = fetch_valid & fetch_ready & ctrl_valid;
  assign in_trap     = (state == TRAP);
  assign halted      = (state == HALT);
  assign state_dbg   = state;

  assign seq_pc = pc + INSN_SIZE;
  assign br_pc  = pc + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
  assign jr_pc  = JUMP_OFS + busA;
  assign j_pc   = JUMP_OFS + {pc[ADDR_W-1:28], imm26, 2'b00};

  // Decode the instruction at pc into a redirect address; branches outrank jumps.
  always_comb begin
    take_br     = 1'b0;
    is_jr       = 1'b0;
    redirect_pc = seq_pc;
    if (branch != 2'b00) begin
      case (op)
        6'b000100: take_br = zero;
        6'b000101: take_br = !zero;
        6'b000111: take_br = !busA[ADDR_W-1] && (busA != '0);
        6'b000110: take_br = busA[ADDR_W-1] || (busA == '0);
        6'b000001: take_br = (branch == 2'b10) ?  busA[ADDR_W-1] :
                             (branch == 2'b01) ? !busA[ADDR_W-1] : 1'b0;
        default:   take_br = 1'b0;
      endcase
      if (take_br) redirect_pc = br_pc;
    end else if (jump) begin
      if (op == 6'd0) begin
        is_jr       = 1'b1;
        redirect_pc = jr_pc;
      end else begin
        redirect_pc = j_pc;
      end
    end
  end

  // Next state, PC and EPC in priority order: halt_req, trap, eret, advance.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    epc_nxt      = epc;
    misalign_nxt = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN, TRAP: begin
        if (halt_req) begin
          state_nxt = HALT;
        end else if (trap) begin
          // A trap raised inside the handler is a double fault: stop cold,
          // keeping the original epc for post-mortem.
          if (state == RUN) begin
            state_nxt = TRAP;
            epc_nxt   = pc;
            pc_nxt    = TRAP_PC;
          end else begin
            state_nxt = HALT;
          end
        end else if (eret && (state == TRAP)) begin
          state_nxt = RUN;
          pc_nxt    = epc;
        end else if (advance) begin
          if (is_jr && (jr_pc[1:0] != 2'b00)) begin
            misalign_nxt = 1'b1;
            if (state == RUN) begin
              state_nxt = TRAP;
              epc_nxt   = pc;
              pc_nxt    = TRAP_PC;
            end else begin
              state_nxt = HALT;
            end
          end else begin
            pc_nxt = redirect_pc;
          end
        end
      end
      default: state_nxt = HALT;
    endcase
  end

  // State, PC, EPC and the misalign pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      epc      <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      epc      <= epc_nxt;
      misalign <= misalign_nxt;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: a table of single-instruction redirect vectors, followed by
// hand-written sequences for reset, stall, trap/eret, double fault, misalign,
// halt and 64-bit wrap-around.
module tb_pc_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        fetch_ready, ctrl_valid, jump, zero, trap, eret, halt_req;
  logic [1:0]  branch;
  logic [5:0]  op;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] busA;
  logic [31:0] pc, epc;
  logic        fetch_valid, in_trap, misalign, halted;
  logic [1:0]  state_dbg;

  logic [63:0] busA64, pc64, epc64;
  logic        fetch_valid64, in_trap64, misalign64, halted64;
  logic [1:0]  state_dbg64;

  pc_gen #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .ctrl_valid(ctrl_valid), .branch(branch),
    .jump(jump), .zero(zero), .op(op), .imm16(imm16), .imm26(imm26),
    .busA(busA), .trap(trap), .eret(eret), .halt_req(halt_req), .epc(epc),
    .in_trap(in_trap), .misalign(misalign), .halted(halted),
    .state_dbg(state_dbg)
  );

  pc_gen #(.ADDR_W(64)) dut64 (
    .clk(clk), .rst(rst), .pc(pc64), .fetch_valid(fetch_valid64),
    .fetch_ready(fetch_ready), .ctrl_valid(ctrl_valid), .branch(branch),
    .jump(jump), .zero(zero), .op(op), .imm16(imm16), .imm26(imm26),
    .busA(busA64), .trap(trap), .eret(eret), .halt_req(halt_req), .epc(epc64),
    .in_trap(in_trap64), .misalign(misalign64), .halted(halted64),
    .state_dbg(state_dbg64)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: expected pc is queued with the stimulus, popped and compared
  // just after the edge.
  task automatic step(input logic [31:0] exp_pc, input string name);
    logic [31:0] want;
    exp_q.push_back(exp_pc);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    chk(name, {32'd0, pc}, {32'd0, want});
  endtask

  // ---------------- driver tasks ----------------
  task automatic clr_inputs();
    fetch_ready = 1'b0; ctrl_valid = 1'b0; branch = 2'b00; jump = 1'b0;
    zero = 1'b0; op = 6'd0; imm16 = 16'd0; imm26 = 26'd0; busA = 32'd0;
    trap = 1'b0; eret = 1'b0; halt_req = 1'b0; busA64 = 64'd0;
  endtask

  task automatic drive_insn(input logic [1:0] b, input logic j, input logic z,
                            input logic [5:0] o, input logic [15:0] i16,
                            input logic [25:0] i26, input logic [31:0] a,
                            input logic rdy);
    fetch_ready = rdy; ctrl_valid = 1'b1; branch = b; jump = j; zero = z;
    op = o; imm16 = i16; imm26 = i26; busA = a;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    step(32'h3000, "rst_pc");
    rst = 1'b0;
    step(32'h3000, "boot_pc");
  endtask

  // Move pc to a known address with a JR (target = 0x3000 + busA).
  task automatic set_pc(input logic [31:0] target);
    drive_insn(2'b00, 1'b1, 1'b0, 6'd0, 16'd0, 26'd0, target - 32'h3000, 1'b1);
    step(target, "set_pc");
    clr_inputs();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [31:0] start;
    logic [1:0]  branch;
    logic        jump;
    logic        zero;
    logic [5:0]  op;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] busa;
    logic        ready;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string n, input logic [31:0] s, input logic [1:0] b,
                         input logic j, input logic z, input logic [5:0] o,
                         input logic [15:0] i16, input logic [25:0] i26,
                         input logic [31:0] a, input logic r, input logic [31:0] e);
    vec_t v;
    v.name = n; v.start = s; v.branch = b; v.jump = j; v.zero = z; v.op = o;
    v.imm16 = i16; v.imm26 = i26; v.busa = a; v.ready = r; v.exp_pc = e;
    vecs.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    //       name            start         br     j     z     op     imm16     imm26     busA          rdy   expected
    add_vec("beq_taken",    32'h3010,     2'b11, 1'b0, 1'b1, 6'd4, 16'hFFFE, 26'h0,    32'h0,        1'b1, 32'h3008);
    add_vec("beq_not",      32'h3010,     2'b11, 1'b0, 1'b0, 6'd4, 16'hFFFE, 26'h0,    32'h0,        1'b1, 32'h3014);
    add_vec("bltz_taken",   32'h3020,     2'b10, 1'b0, 1'b0, 6'd1, 16'h0004, 26'h0,    32'h8000_0000, 1'b1, 32'h3030);
    add_vec("bgez_not",     32'h3020,     2'b01, 1'b0, 1'b0, 6'd1, 16'h0004, 26'h0,    32'h8000_0000, 1'b1, 32'h3024);
    add_vec("bgez_taken",   32'h3020,     2'b01, 1'b0, 1'b0, 6'd1, 16'h0004, 26'h0,    32'h10,       1'b1, 32'h3030);
    add_vec("regimm_b11",   32'h3020,     2'b11, 1'b0, 1'b0, 6'd1, 16'h0004, 26'h0,    32'h0,        1'b1, 32'h3024);
    add_vec("bne_taken",    32'h3000,     2'b11, 1'b0, 1'b0, 6'd5, 16'h0010, 26'h0,    32'h0,        1'b1, 32'h3040);
    add_vec("bne_not",      32'h3000,     2'b11, 1'b0, 1'b1, 6'd5, 16'h0010, 26'h0,    32'h0,        1'b1, 32'h3004);
    add_vec("bgtz_taken",   32'h3000,     2'b11, 1'b0, 1'b0, 6'd7, 16'h0008, 26'h0,    32'h5,        1'b1, 32'h3020);
    add_vec("bgtz_zero",    32'h3000,     2'b11, 1'b0, 1'b0, 6'd7, 16'h0008, 26'h0,    32'h0,        1'b1, 32'h3004);
    add_vec("blez_zero",    32'h3000,     2'b11, 1'b0, 1'b0, 6'd6, 16'h0008, 26'h0,    32'h0,        1'b1, 32'h3020);
    add_vec("blez_neg",     32'h3000,     2'b11, 1'b0, 1'b0, 6'd6, 16'h0008, 26'h0,    32'hFFFF_FFFF, 1'b1, 32'h3020);
    add_vec("blez_pos",     32'h3000,     2'b11, 1'b0, 1'b0, 6'd6, 16'h0008, 26'h0,    32'h1,        1'b1, 32'h3004);
    add_vec("jr",           32'h3020,     2'b00, 1'b1, 1'b0, 6'd0, 16'h0,    26'h0,    32'h100,      1'b1, 32'h3100);
    add_vec("j",            32'h3000,     2'b00, 1'b1, 1'b0, 6'd2, 16'h0,    26'h40,   32'h0,        1'b1, 32'h3100);
    add_vec("jal_upper",    32'h1000_0000, 2'b00, 1'b1, 1'b0, 6'd3, 16'h0,   26'h0,    32'h0,        1'b1, 32'h1000_3000);
    add_vec("br_over_jump", 32'h3000,     2'b11, 1'b1, 1'b0, 6'd4, 16'h0010, 26'h40,   32'h0,        1'b1, 32'h3004);
    add_vec("other_op",     32'h3000,     2'b11, 1'b0, 1'b1, 6'd2, 16'h0010, 26'h0,    32'h0,        1'b1, 32'h3004);
    add_vec("stall",        32'h3010,     2'b00, 1'b0, 1'b0, 6'd0, 16'h0,    26'h0,    32'h0,        1'b0, 32'h3010);
    add_vec("plain",        32'h3008,     2'b00, 1'b0, 1'b0, 6'd0, 16'h0,    26'h0,    32'h0,        1'b1, 32'h300C);

    // Reset state and boot cycle.
    clr_inputs();
    rst = 1'b1;
    step(32'h3000, "rst_pc");
    chk("rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
    chk("rst_epc", {32'd0, epc}, 64'd0);
    chk("rst_flags", {61'd0, in_trap, misalign, halted}, 64'd0);
    rst = 1'b0;
    drive_insn(2'b00, 1'b0, 1'b0, 6'd0, 16'd0, 26'd0, 32'd0, 1'b1);
    step(32'h3000, "boot_no_advance");
    chk("run_fetch_valid", {63'd0, fetch_valid}, 64'd1);
    step(32'h3004, "seq_1");
    step(32'h3008, "seq_2");
    step(32'h300C, "seq_3");
    clr_inputs();

    // Table of redirect vectors.
    foreach (vecs[i]) begin
      set_pc(vecs[i].start);
      drive_insn(vecs[i].branch, vecs[i].jump, vecs[i].zero, vecs[i].op,
                 vecs[i].imm16, vecs[i].imm26, vecs[i].busa, vecs[i].ready);
      step(vecs[i].exp_pc, vecs[i].name);
      chk({vecs[i].name, "_misalign"}, {63'd0, misalign}, 64'd0);
      clr_inputs();
    end

    // Two-cycle stall, then the fetch completes.
    set_pc(32'h3010);
    drive_insn(2'b00, 1'b0, 1'b0, 6'd0, 16'd0, 26'd0, 32'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(32'h3010, "stall_hold");
      chk("stall_fetch_valid", {63'd0, fetch_valid}, 64'd1);
    end
    fetch_ready = 1'b1;
    step(32'h3014, "stall_release");
    clr_inputs();

    // Trap, eret, eret-in-RUN ignored, double fault.
    set_pc(32'h3040);
    trap = 1'b1;
    step(32'h4180, "trap_pc");
    chk("trap_epc", {32'd0, epc}, 64'h3040);
    chk("trap_in_trap", {63'd0, in_trap}, 64'd1);
    trap = 1'b0; eret = 1'b1;
    step(32'h3040, "eret_pc");
    chk("eret_in_trap", {63'd0, in_trap}, 64'd0);
    drive_insn(2'b00, 1'b0, 1'b0, 6'd0, 16'd0, 26'd0, 32'd0, 1'b1);
    step(32'h3044, "eret_in_run_ignored");
    chk("eret_in_run_state", {63'd0, in_trap}, 64'd0);
    clr_inputs();
    trap = 1'b1;
    step(32'h4180, "trap2_pc");
    chk("trap2_epc", {32'd0, epc}, 64'h3044);
    step(32'h4180, "double_fault_pc");
    chk("double_fault_halted", {63'd0, halted}, 64'd1);
    chk("double_fault_fetch_valid", {63'd0, fetch_valid}, 64'd0);
    clr_inputs();
    drive_insn(2'b00, 1'b0, 1'b0, 6'd0, 16'd0, 26'd0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(32'h4180, "halt_hold");
      chk("halt_stays", {63'd0, halted}, 64'd1);
    end
    do_reset();
    chk("post_halt_rst", {62'd0, halted, in_trap}, 64'd0);
    chk("post_halt_epc", {32'd0, epc}, 64'd0);

    // Trap beats a simultaneous redirect; trap+eret in TRAP halts.
    set_pc(32'h3060);
    drive_insn(2'b00, 1'b1, 1'b0, 6'd0, 16'd0, 26'd0, 32'h200, 1'b1);
    trap = 1'b1;
    step(32'h4180, "trap_vs_redirect_pc");
    chk("trap_vs_redirect_epc", {32'd0, epc}, 64'h3060);
    clr_inputs();
    trap = 1'b1; eret = 1'b1;
    step(32'h4180, "trap_eret_pc");
    chk("trap_eret_halted", {63'd0, halted}, 64'd1);
    do_reset();

    // Misaligned JR: trap entry from RUN, halt from TRAP.
    set_pc(32'h3050);
    drive_insn(2'b00, 1'b1, 1'b0, 6'd0, 16'd0, 26'd0, 32'h102, 1'b1);
    step(32'h4180, "misalign_pc");
    chk("misalign_pulse", {63'd0, misalign}, 64'd1);
    chk("misalign_epc", {32'd0, epc}, 64'h3050);
    chk("misalign_in_trap", {63'd0, in_trap}, 64'd1);
    clr_inputs();
    step(32'h4180, "misalign_idle");
    chk("misalign_one_cycle", {63'd0, misalign}, 64'd0);
    drive_insn(2'b00, 1'b1, 1'b0, 6'd0, 16'd0, 26'd0, 32'h103, 1'b1);
    step(32'h4180, "misalign_in_trap_pc");
    chk("misalign_in_trap_halted", {63'd0, halted}, 64'd1);
    chk("misalign_in_trap_pulse", {63'd0, misalign}, 64'd1);
    do_reset();

    // halt_req outranks an advance and holds pc.
    set_pc(32'h3070);
    drive_insn(2'b00, 1'b0, 1'b0, 6'd0, 16'd0, 26'd0, 32'd0, 1'b1);
    halt_req = 1'b1;
    step(32'h3070, "halt_req_pc");
    chk("halt_req_halted", {63'd0, halted}, 64'd1);

    // 64-bit instance: wrap from FFFF_FFFF_FFFF_FFFC to 0.
    do_reset();
    drive_insn(2'b00, 1'b1, 1'b0, 6'd0, 16'd0, 26'd0, 32'd0, 1'b1);
    busA64 = 64'hFFFF_FFFF_FFFF_CFFC;
    step(32'h3000, "w64_side_pc");
    chk("w64_pc_top", pc64, 64'hFFFF_FFFF_FFFF_FFFC);
    drive_insn(2'b00, 1'b0, 1'b0, 6'd0, 16'd0, 26'd0, 32'd0, 1'b1);
    busA64 = 64'd0;
    step(32'h3004, "w64_side_pc2");
    chk("w64_pc_wrap", pc64, 64'd0);
    chk("w64_flags", {61'd0, misalign64, in_trap64, halted64}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
